wb_stage: RTL and testbench

Writeback stage of the integer pipeline, directly downstream of the MEM/WB pipeline register. Each cycle it consumes that register's valid/control/destination/result bundle and commits the result into an 8-entry x 32-bit architectural register file. It also provides:
- two bypassed read ports for decode;
- a busy-bit scoreboard for in-flight destinations;
- a retired-instruction counter;
- a sticky halt flag.

---
 rtl/wb_stage.sv | 83 ++++++++
 tb/tb_wb_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: commits MEM/WB results into an 8x32 register file with
// bypassed decode reads, a destination busy scoreboard, a retire counter and a sticky halt.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  ctrl_in,
  input  logic [2:0]  dst_idx_in,
  input  logic [31:0] result_in,
  input  logic [2:0]  rd_idx_a,
  input  logic [2:0]  rd_idx_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        claim_valid,
  input  logic [2:0]  claim_idx,
  output logic [7:0]  busy,
  output logic [31:0] retire_count,
  output logic        halted
);

  typedef enum logic [1:0] {
    WSIZE_WORD  = 2'b00,
    WSIZE_HALF  = 2'b01,
    WSIZE_BYTE  = 2'b10,
    WSIZE_WORD2 = 2'b11
  } wsize_e;

  logic [31:0] regs [8];
  logic        commit;
  logic        write;
  wsize_e      wsize;
  logic [31:0] old_val;
  logic [31:0] merged;
  logic [7:0]  busy_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    commit  = valid_in & ~halted;
    write   = commit & ctrl_in[0];
    wsize   = wsize_e'(ctrl_in[2:1]);
    old_val = regs[dst_idx_in];
    merged  = result_in;
    case (wsize)
      WSIZE_HALF: merged = {old_val[31:16], result_in[15:0]};
      WSIZE_BYTE: merged = {old_val[31:8],  result_in[7:0]};
      default:    merged = result_in;
    endcase
  end

  // Write-through bypass: a read of the register being written sees the merged value.
  always_comb begin
    rd_data_a = (write && rd_idx_a == dst_idx_in) ? merged : regs[rd_idx_a];
    rd_data_b = (write && rd_idx_b == dst_idx_in) ? merged : regs[rd_idx_b];
  end

  // A claim outranks a release of the same register in the same cycle.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < 8; i++) begin
      if (claim_valid && claim_idx == 3'(i))
        busy_next[i] = 1'b1;
      else if (write && dst_idx_in == 3'(i))
        busy_next[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is reset explicitly because architectural state must read 0 after reset.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      busy         <= '0;
      retire_count <= '0;
      halted       <= 1'b0;
    end else begin
      if (write) regs[dst_idx_in] <= merged;
      if (commit) retire_count <= retire_count + 32'd1;
      if (commit && ctrl_in[3]) halted <= 1'b1;
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [6:0]  ctrl_in;
  logic [2:0]  dst_idx_in;
  logic [31:0] result_in;
  logic [2:0]  rd_idx_a, rd_idx_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        claim_valid;
  logic [2:0]  claim_idx;
  logic [7:0]  busy;
  logic [31:0] retire_count;
  logic        halted;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_cnt;

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .ctrl_in      (ctrl_in),
    .dst_idx_in   (dst_idx_in),
    .result_in    (result_in),
    .rd_idx_a     (rd_idx_a),
    .rd_idx_b     (rd_idx_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .claim_valid  (claim_valid),
    .claim_idx    (claim_idx),
    .busy         (busy),
    .retire_count (retire_count),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] c, input logic [2:0] d,
                       input logic [31:0] r);
    valid_in   = v;
    ctrl_in    = c;
    dst_idx_in = d;
    result_in  = r;
  endtask

  // Advance one rising edge and return to the falling edge for the next step.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; claim_valid = 1'b0; claim_idx = '0;
    rd_idx_a = '0; rd_idx_b = '0;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    // Commit and claim during reset must be discarded.
    drive(1'b1, 7'b0000001, 3'd0, 32'h1111_1111);
    claim_valid = 1'b1; claim_idx = 3'd0;
    tick();
    rst = 1'b0; claim_valid = 1'b0;
    drive(1'b0, '0, '0, '0);
    exp_cnt = 32'd0;

    for (int i = 0; i < 8; i++) begin
      rd_idx_a = 3'(i); rd_idx_b = 3'(7 - i);
      push(32'h0); push(32'h0);
      #1;
      check("reset_rd_a", rd_data_a);
      check("reset_rd_b", rd_data_b);
    end
    push(32'h0); check("reset_busy", 32'(busy));
    push(32'h0); check("reset_count", retire_count);
    push(32'h0); check("reset_halted", 32'(halted));

    // Full write with both ports bypassing.
    drive(1'b1, 7'b0000001, 3'd3, 32'hDEAD_BEEF);
    rd_idx_a = 3'd3; rd_idx_b = 3'd3;
    push(32'hDEAD_BEEF); push(32'hDEAD_BEEF);
    #1;
    check("bypass_a", rd_data_a);
    check("bypass_b", rd_data_b);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'hDEAD_BEEF); push(exp_cnt);
    #1;
    check("array_r3", rd_data_a);
    check("count_after_write", retire_count);

    // Half-word merge.
    drive(1'b1, 7'b0000011, 3'd3, 32'h0000_1234);
    push(32'hDEAD_1234);
    #1;
    check("bypass_half", rd_data_a);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'hDEAD_1234); #1; check("array_half", rd_data_a);

    // Byte merge.
    drive(1'b1, 7'b0000101, 3'd3, 32'h0000_00FF);
    push(32'hDEAD_12FF);
    #1;
    check("bypass_byte", rd_data_b);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'hDEAD_12FF); #1; check("array_byte", rd_data_a);

    // wsize=11 is a full write; reserved bits set; port b bypasses while a reads r3.
    drive(1'b1, 7'b1110111, 3'd4, 32'hCAFE_F00D);
    rd_idx_b = 3'd4;
    push(32'hDEAD_12FF); push(32'hCAFE_F00D);
    #1;
    check("nobypass_a", rd_data_a);
    check("bypass_w11_b", rd_data_b);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'hCAFE_F00D); push(exp_cnt); push(32'h0);
    #1;
    check("array_r4", rd_data_b);
    check("count_4", retire_count);
    check("reserved_no_halt", 32'(halted));

    // Scoreboard.
    claim_valid = 1'b1; claim_idx = 3'd5;
    tick();
    claim_valid = 1'b0;
    push(32'h20); #1; check("busy_claim5", 32'(busy));
    drive(1'b1, 7'b0000000, 3'd5, 32'h5555_5555);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'h20); push(exp_cnt);
    #1;
    check("busy_we0_hold", 32'(busy));
    check("count_we0", retire_count);
    drive(1'b1, 7'b0000001, 3'd5, 32'h5555_5555);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'h00); #1; check("busy_release5", 32'(busy));
    drive(1'b1, 7'b0000001, 3'd2, 32'h2222_2222);
    claim_valid = 1'b1; claim_idx = 3'd2;
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    claim_valid = 1'b0;
    push(32'h04); #1; check("busy_claim_wins", 32'(busy));

    // Halt.
    drive(1'b1, 7'b0001001, 3'd1, 32'd7);
    rd_idx_a = 3'd1;
    push(32'd7); #1; check("halt_bypass", rd_data_a);
    exp_cnt++;
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'd1); push(exp_cnt); push(32'd7);
    #1;
    check("halted_set", 32'(halted));
    check("count_halt", retire_count);
    check("halt_r1", rd_data_a);
    drive(1'b1, 7'b0000001, 3'd1, 32'd9);
    push(32'd7); #1; check("halted_no_bypass", rd_data_a);
    tick();
    // While halted, a write to busy r2 must not clear it, but a claim still sets r6.
    drive(1'b1, 7'b0000001, 3'd2, 32'hBAD0_BAD0);
    claim_valid = 1'b1; claim_idx = 3'd6;
    tick();
    drive(1'b0, '0, '0, '0);
    claim_valid = 1'b0;
    push(32'd7); push(exp_cnt); push(32'h44);
    #1;
    check("halted_r1_kept", rd_data_a);
    check("halted_count_kept", retire_count);
    check("halted_busy", 32'(busy));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 32'd0;
    push(32'd0); push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    #1;
    check("rst_halted", 32'(halted));
    check("rst_r1", rd_data_a);
    check("rst_r0_discarded", 32'(dut.regs[0]));
    check("rst_busy", 32'(busy));
    check("rst_count", retire_count);

    // Counter wrap.
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    drive(1'b1, 7'b0000000, 3'd0, 32'h0);
    tick();
    drive(1'b0, '0, '0, '0);
    push(32'h0); #1; check("count_wrap", retire_count);
    tick();
    push(32'h0); #1; check("count_idle_hold", retire_count);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected values left, 0 required", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
